// File: rtl/segment_mask_renderer.sv
// Segment-mask renderer: loads run-length mask records from the ioctl stream and gates
// covered pixels by live segment state. Optional macro: SEGMENT_STATE_LATCH_EN (state latched at vblank).
module segment_mask_renderer #(
    parameter logic [24:0] START_ADDRESS = 25'h17BB00,
    parameter int          CLOCK_RATIO   = 4,
    parameter int          ENTRY_COUNT   = 18720,
    parameter int          ID_WIDTH      = 10,
    parameter int          COORD_WIDTH   = 10
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               ioctl_wr,
    input  logic [24:0]                        ioctl_addr,
    input  logic [15:0]                        ioctl_dout,
    input  logic                               state_wr,
    input  logic [ID_WIDTH-1:0]                state_addr,
    input  logic                               state_data,
    input  logic                               vblank,
    input  logic                               hblank,
    input  logic [COORD_WIDTH-1:0]             video_x,
    input  logic [COORD_WIDTH-1:0]             video_y,
    output logic                               segment_active,
    output logic                               segment_enabled,
    output logic [ID_WIDTH-1:0]                segment_id,
    output logic [$clog2(ENTRY_COUNT+1)-1:0]   entry_count,
    output logic                               load_overflow
);
    localparam int REC_W     = ID_WIDTH + 3 * COORD_WIDTH;
    localparam int REC_BYTES = (REC_W + 7) / 8;
    localparam int CNT_W     = $clog2(ENTRY_COUNT + 1);
    localparam int ADDR_W    = (ENTRY_COUNT > 1) ? $clog2(ENTRY_COUNT) : 1;
    localparam int VC_W      = (CLOCK_RATIO > 1) ? $clog2(CLOCK_RATIO) : 1;
    localparam int ASM_W     = $clog2(REC_BYTES + 1);
    localparam int STATES    = 2 ** ID_WIDTH;
    localparam logic [CNT_W-1:0] ENTRY_MAX = CNT_W'(ENTRY_COUNT);
    localparam logic [VC_W-1:0]  VC_RELOAD = VC_W'(CLOCK_RATIO - 1);
    localparam logic [ASM_W-1:0] ASM_LAST  = ASM_W'(REC_BYTES - 1);

    typedef enum logic {RS_IDLE, RS_RUN} render_state_t;

    logic [15:0]                  ser_data;
    logic [1:0]                   ser_cnt;
    logic [8*(REC_BYTES-1)-1:0]   asm_buf;
    logic [ASM_W-1:0]             asm_cnt;
    logic                         load_hit, load_restart, byte_push, rec_done, rec_store;
    logic [8*REC_BYTES-1:0]       rec_bytes;
    logic [REC_W-1:0]             rec_word;

    always_comb begin
        load_hit     = ioctl_wr && (ioctl_addr >= START_ADDRESS);
        load_restart = ioctl_wr && (ioctl_addr == START_ADDRESS);
        byte_push    = (ser_cnt != 2'd0) && !load_hit;
        rec_bytes    = {ser_data[7:0], asm_buf};
        rec_word     = rec_bytes[REC_W-1:0];
        rec_done     = byte_push && (asm_cnt == ASM_LAST);
        rec_store    = rec_done && (entry_count < ENTRY_MAX);
    end

    // A new ioctl word always wins over a byte still waiting in the serialiser.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ser_data      <= '0;
            ser_cnt       <= '0;
            asm_buf       <= '0;
            asm_cnt       <= '0;
            entry_count   <= '0;
            load_overflow <= 1'b0;
        end else if (load_hit) begin
            ser_data <= ioctl_dout;
            ser_cnt  <= 2'd2;
            if (load_restart) begin
                asm_cnt       <= '0;
                entry_count   <= '0;
                load_overflow <= 1'b0;
            end
        end else if (byte_push) begin
            ser_data <= {8'h00, ser_data[15:8]};
            ser_cnt  <= ser_cnt - 2'd1;
            asm_buf  <= rec_bytes[8*REC_BYTES-1:8];
            if (rec_done) begin
                asm_cnt <= '0;
                if (rec_store) entry_count <= entry_count + CNT_W'(1);
                else           load_overflow <= 1'b1;
            end else begin
                asm_cnt <= asm_cnt + ASM_W'(1);
            end
        end
    end

    logic [REC_W-1:0]        rec_ram [ENTRY_COUNT];
    logic [REC_W-1:0]        rec_q;
    logic [CNT_W-1:0]        read_addr;

    always_ff @(posedge clk) begin
        if (rec_store) rec_ram[entry_count[ADDR_W-1:0]] <= rec_word;
        rec_q <= rec_ram[read_addr[ADDR_W-1:0]];
    end

    render_state_t           render_state;
    logic [VC_W-1:0]         vid_counter;
    logic [COORD_WIDTH-1:0]  remaining;
    logic [ID_WIDTH-1:0]     run_id;
    logic [ID_WIDTH-1:0]     rec_id, lookup_id, pix_id;
    logic [COORD_WIDTH-1:0]  rec_x, rec_y, rec_len;
    logic                    strobe, rec_valid, rec_hit, pix_now, pix_active, state_q;

    always_comb begin
        strobe    = (vid_counter == '0);
        rec_id    = rec_q[ID_WIDTH-1:0];
        rec_x     = rec_q[ID_WIDTH +: COORD_WIDTH];
        rec_y     = rec_q[ID_WIDTH + COORD_WIDTH +: COORD_WIDTH];
        rec_len   = rec_q[ID_WIDTH + 2*COORD_WIDTH +: COORD_WIDTH];
        rec_valid = (read_addr < entry_count);
        rec_hit   = rec_valid && (rec_len != '0) && (video_x == rec_x) && (video_y == rec_y);
        pix_now   = !vblank && !hblank && ((render_state == RS_RUN) || rec_hit);
        lookup_id = (render_state == RS_RUN) ? run_id : rec_id;
    end

    // Zero-length records are skipped on any strobe outside vblank, so a skip during the
    // horizontal blank does not cost the first visible pixel of the line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vid_counter  <= VC_RELOAD;
            render_state <= RS_IDLE;
            read_addr    <= '0;
            remaining    <= '0;
            run_id       <= '0;
            pix_active   <= 1'b0;
            pix_id       <= '0;
        end else begin
            vid_counter <= strobe ? VC_RELOAD : vid_counter - VC_W'(1);
            if (vblank) begin
                read_addr    <= '0;
                render_state <= RS_IDLE;
            end else if (hblank) begin
                render_state <= RS_IDLE;
                if (strobe && render_state == RS_IDLE && rec_valid && rec_len == '0)
                    read_addr <= read_addr + CNT_W'(1);
            end else if (strobe) begin
                if (render_state == RS_RUN) begin
                    remaining <= remaining - COORD_WIDTH'(1);
                    if (remaining == COORD_WIDTH'(1)) begin
                        render_state <= RS_IDLE;
                        read_addr    <= read_addr + CNT_W'(1);
                    end
                end else if (rec_valid) begin
                    if (rec_len == '0) begin
                        read_addr <= read_addr + CNT_W'(1);
                    end else if (rec_hit) begin
                        run_id    <= rec_id;
                        remaining <= rec_len - COORD_WIDTH'(1);
                        if (rec_len == COORD_WIDTH'(1)) read_addr <= read_addr + CNT_W'(1);
                        else                            render_state <= RS_RUN;
                    end
                end
            end
            if (strobe) begin
                pix_active <= pix_now;
                pix_id     <= pix_now ? lookup_id : '0;
            end
        end
    end

    logic state_ram [STATES];

`ifdef SEGMENT_STATE_LATCH_EN
    logic                shadow_ram [STATES];
    logic                vblank_d, copy_busy;
    logic [ID_WIDTH-1:0] copy_idx;

    always_ff @(posedge clk) begin
        if (state_wr) shadow_ram[state_addr] <= state_data;
    end

    // Copy walks every ID once per vblank; losing vblank aborts it until the next one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vblank_d  <= 1'b0;
            copy_busy <= 1'b0;
            copy_idx  <= '0;
        end else begin
            vblank_d <= vblank;
            if (vblank && !vblank_d) begin
                copy_busy <= 1'b1;
                copy_idx  <= '0;
            end else if (!vblank) begin
                copy_busy <= 1'b0;
            end else if (copy_busy) begin
                copy_idx <= copy_idx + ID_WIDTH'(1);
                if (copy_idx == '1) copy_busy <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (copy_busy && vblank) state_ram[copy_idx] <= shadow_ram[copy_idx];
        if (strobe) state_q <= state_ram[lookup_id];
    end
`else
    always_ff @(posedge clk) begin
        if (state_wr) state_ram[state_addr] <= state_data;
        if (strobe) state_q <= state_ram[lookup_id];
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            segment_active  <= 1'b0;
            segment_enabled <= 1'b0;
            segment_id      <= '0;
        end else begin
            segment_active  <= pix_active;
            segment_enabled <= pix_active & state_q;
            segment_id      <= pix_id;
        end
    end
endmodule

// File: tb/tb_segment_mask_renderer.sv
// Directed bench for segment_mask_renderer: loads mask records, renders pixels and
// compares the registered outputs against hand-computed expectations.
`timescale 1ns/1ps
module tb_segment_mask_renderer;
    localparam logic [24:0] START = 25'h17BB00;
    localparam int CR  = 4;
    localparam int EC  = 4;
    localparam int IDW = 10;
    localparam int CW  = 10;
    localparam int ECW = $clog2(EC + 1);
`ifdef SEGMENT_STATE_LATCH_EN
    localparam logic LATCH = 1'b1;
`else
    localparam logic LATCH = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset;
    logic           ioctl_wr;
    logic [24:0]    ioctl_addr;
    logic [15:0]    ioctl_dout;
    logic           state_wr;
    logic [IDW-1:0] state_addr;
    logic           state_data;
    logic           vblank, hblank;
    logic [CW-1:0]  video_x, video_y;
    logic           segment_active, segment_enabled;
    logic [IDW-1:0] segment_id;
    logic [ECW-1:0] entry_count;
    logic           load_overflow;

    int total = 0;
    int bad   = 0;
    int tb_vc;
    logic [7:0] byte_q [$];

    segment_mask_renderer #(
        .START_ADDRESS(START), .CLOCK_RATIO(CR), .ENTRY_COUNT(EC),
        .ID_WIDTH(IDW), .COORD_WIDTH(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .state_wr(state_wr), .state_addr(state_addr), .state_data(state_data),
        .vblank(vblank), .hblank(hblank), .video_x(video_x), .video_y(video_y),
        .segment_active(segment_active), .segment_enabled(segment_enabled),
        .segment_id(segment_id), .entry_count(entry_count), .load_overflow(load_overflow)
    );

    always #5 clk = ~clk;

    // Reference pixel-phase counter: reads CR-1 right after each pixel strobe edge.
    always @(posedge clk or posedge reset) begin
        if (reset) tb_vc <= CR - 1;
        else       tb_vc <= (tb_vc == 0) ? CR - 1 : tb_vc - 1;
    end

    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag, input logic act, input logic en, input int id);
        checkValue({tag, ".active"}, 32'(segment_active), 32'(act));
        checkValue({tag, ".enabled"}, 32'(segment_enabled), 32'(en));
        checkValue({tag, ".id"}, 32'(segment_id), 32'(id));
    endtask

    task automatic checkLoad(input string tag, input int cnt, input logic ovf);
        checkValue({tag, ".count"}, 32'(entry_count), 32'(cnt));
        checkValue({tag, ".overflow"}, 32'(load_overflow), 32'(ovf));
    endtask

    task automatic addRecord(input int id, input int x, input int y, input int len);
        logic [39:0] rec;
        rec = {len[9:0], y[9:0], x[9:0], id[9:0]};
        for (int i = 0; i < 5; i++) byte_q.push_back(rec[8*i +: 8]);
    endtask

    task automatic sendWord(input logic [24:0] addr, input logic [15:0] data);
        @(negedge clk);
        ioctl_wr = 1'b1; ioctl_addr = addr; ioctl_dout = data;
        @(negedge clk);
        ioctl_wr = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic streamQueue(input int first_word);
        logic [7:0] lo, hi;
        int w;
        w = first_word;
        while (byte_q.size() > 0) begin
            lo = byte_q.pop_front();
            hi = (byte_q.size() > 0) ? byte_q.pop_front() : 8'h00;
            sendWord(START + 25'(2 * w), {hi, lo});
            w++;
        end
    endtask

    task automatic setState(input int id, input logic val);
        @(negedge clk);
        state_wr = 1'b1; state_addr = IDW'(id); state_data = val;
        @(negedge clk);
        state_wr = 1'b0;
    endtask

    // Present one pixel, let it pass a strobe edge, then sample once its outputs are registered.
    task automatic applyStimulus(input int x, input int y, input logic hb, input logic vb);
        int guard;
        guard = 0;
        @(negedge clk);
        video_x = CW'(x); video_y = CW'(y); hblank = hb; vblank = vb;
        do begin
            @(posedge clk); #1;
            guard++;
        end while (tb_vc != CR - 1 && guard < 4 * CR);
        @(posedge clk); #1;
    endtask

    task automatic blankPixels(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 1'b0, 1'b1);
    endtask

    initial begin
        reset = 1'b1; ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0;
        state_wr = 1'b0; state_addr = '0; state_data = 1'b0;
        vblank = 1'b0; hblank = 1'b0; video_x = '0; video_y = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset", 1'b0, 1'b0, 0);
        checkLoad("reset", 0, 1'b0);
        reset = 1'b0;
        $display("[TB] two-record line");

        addRecord(7, 10, 5, 3);
        addRecord(8, 13, 5, 1);
        streamQueue(0);
        checkLoad("load2", 2, 1'b0);
        setState(7, 1'b1);
        setState(8, 1'b0);
        blankPixels(4);
        applyStimulus(9, 5, 1'b0, 1'b0);  checkOutput("l5.x9", 1'b0, 1'b0, 0);
        applyStimulus(10, 5, 1'b0, 1'b0); checkOutput("l5.x10", 1'b1, 1'b1, 7);
        applyStimulus(11, 5, 1'b0, 1'b0); checkOutput("l5.x11", 1'b1, 1'b1, 7);
        applyStimulus(12, 5, 1'b0, 1'b0); checkOutput("l5.x12", 1'b1, 1'b1, 7);
        applyStimulus(13, 5, 1'b0, 1'b0); checkOutput("l5.x13", 1'b1, 1'b0, 8);
        applyStimulus(14, 5, 1'b0, 1'b0); checkOutput("l5.x14", 1'b0, 1'b0, 0);

        $display("[TB] state change mid-frame");
        blankPixels(4);
        applyStimulus(10, 5, 1'b0, 1'b0); checkOutput("mid.x10", 1'b1, 1'b1, 7);
        setState(7, 1'b0);
        applyStimulus(11, 5, 1'b0, 1'b0); checkOutput("mid.x11", 1'b1, LATCH, 7);
        blankPixels(300);
        applyStimulus(10, 5, 1'b0, 1'b0); checkOutput("next.x10", 1'b1, 1'b0, 7);

        $display("[TB] zero-length skip");
        addRecord(3, 0, 0, 0);
        addRecord(1, 0, 0, 2);
        streamQueue(0);
        checkLoad("skip", 2, 1'b0);
        setState(1, 1'b1);
        blankPixels(4);
        applyStimulus(0, 0, 1'b1, 1'b0);  checkOutput("skip.hb", 1'b0, 1'b0, 0);
        applyStimulus(0, 0, 1'b0, 1'b0);  checkOutput("skip.x0", 1'b1, 1'b1, 1);
        applyStimulus(1, 0, 1'b0, 1'b0);  checkOutput("skip.x1", 1'b1, 1'b1, 1);
        applyStimulus(2, 0, 1'b0, 1'b0);  checkOutput("skip.x2", 1'b0, 1'b0, 0);

        $display("[TB] overflow and restart");
        for (int i = 0; i < 4; i++) addRecord(i, 20 + i, 9, 1);
        streamQueue(0);
        checkLoad("full", 4, 1'b0);
        addRecord(9, 0, 9, 1);
        streamQueue(10);
        checkLoad("over", 4, 1'b1);
        sendWord(START, 16'h0000);
        checkLoad("restart", 0, 1'b0);

        $display("[TB] reset during run");
        addRecord(7, 10, 5, 3);
        addRecord(8, 13, 5, 1);
        streamQueue(0);
        setState(7, 1'b1);
        blankPixels(4);
        applyStimulus(10, 5, 1'b0, 1'b0); checkOutput("rr.x10", 1'b1, 1'b1, 7);
        applyStimulus(11, 5, 1'b0, 1'b0); checkOutput("rr.x11", 1'b1, 1'b1, 7);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("rr.reset", 1'b0, 1'b0, 0);
        checkLoad("rr.reset", 0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        blankPixels(4);
        applyStimulus(10, 5, 1'b0, 1'b0); checkOutput("rr.after.x10", 1'b0, 1'b0, 0);
        applyStimulus(11, 5, 1'b0, 1'b0); checkOutput("rr.after.x11", 1'b0, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
